// File: rtl/cpu_trace_streamer.sv
// cpu_trace_streamer: commit-trace unit for the single-cycle MIPS core.
// Commit records {pc, inst, reg write} are queued in a FIFO. Each record leaves
// as tagged beats on a valid/ready stream: PC, INST, WBINFO, then WDATA if the
// record wrote a register. A shadow register file tracks the writes that have
// been streamed, and on request it is streamed out as NREG SNAPREG beats.
// Ports:
//   clk_in, reset (async, active-low)
//   trace_en, commit_valid, commit_pc, commit_inst, rf_we, rf_waddr, rf_wdata : commit side
//   snap_req                                        : one-cycle snapshot request
//   out_valid, out_ready, out_data, out_tag, out_idx : output stream
//   snap_busy, overflow, drop_cnt                    : status
module cpu_trace_streamer #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned NREG      = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned FILTER_WB = 0,
  parameter int unsigned DROP_W    = 16,
  localparam int unsigned AW       = $clog2(NREG)
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              trace_en,
  input  logic              commit_valid,
  input  logic [DATA_W-1:0] commit_pc,
  input  logic [DATA_W-1:0] commit_inst,
  input  logic              rf_we,
  input  logic [AW-1:0]     rf_waddr,
  input  logic [DATA_W-1:0] rf_wdata,
  input  logic              snap_req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_tag,
  output logic [AW-1:0]     out_idx,
  output logic              snap_busy,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [2:0] TAG_PC    = 3'd0;
  localparam logic [2:0] TAG_INST  = 3'd1;
  localparam logic [2:0] TAG_WB    = 3'd2;
  localparam logic [2:0] TAG_WDATA = 3'd3;
  localparam logic [2:0] TAG_SNAP  = 3'd4;

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] inst;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [DATA_W-1:0] wdata;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ENTRY = 2'd1, S_SNAP = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [1:0]        beat_q, beat_d;
  logic [AW-1:0]     sidx_q, sidx_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [2:0]        out_tag_q, out_tag_d;
  logic [AW-1:0]     out_idx_q, out_idx_d;
  logic              snap_busy_q, snap_busy_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] shadow_q [NREG];
  logic [DATA_W-1:0] shadow_d [NREG];
  entry_t            mem_q [DEPTH];

  entry_t            in_c, head_c;
  logic [DATA_W-1:0] wbinfo_c;
  logic              push_req_c, push_c, pop_c, drop_c, hs_c;

  assign push_req_c = trace_en & commit_valid & ((FILTER_WB != 0) ? rf_we : 1'b1);

  // Next-state, FIFO bookkeeping and output beat selection
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    sidx_d      = sidx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    out_idx_d   = out_idx_q;
    // requests while pending or streaming merge into the one snapshot
    snap_busy_d = snap_busy_q | snap_req;
    overflow_d  = overflow_q;
    drop_cnt_d  = drop_cnt_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    shadow_d    = shadow_q;
    pop_c       = 1'b0;
    hs_c        = out_valid_q & out_ready;

    in_c.pc     = commit_pc;
    in_c.inst   = commit_inst;
    in_c.we     = rf_we;
    in_c.waddr  = rf_waddr;
    in_c.wdata  = rf_wdata;
    head_c      = mem_q[rd_ptr_q];

    wbinfo_c               = '0;
    wbinfo_c[DATA_W-1]     = head_c.we;
    wbinfo_c[AW-1:0]       = head_c.waddr;

    case (state_q)
      S_IDLE: begin
        if (snap_busy_q) begin
          // a pending snapshot takes priority over queued entries
          state_d     = S_SNAP;
          sidx_d      = '0;
          out_valid_d = 1'b1;
          out_tag_d   = TAG_SNAP;
          out_idx_d   = '0;
          out_data_d  = shadow_q[0];
        end else if (count_q != '0) begin
          state_d     = S_ENTRY;
          beat_d      = 2'd0;
          out_valid_d = 1'b1;
          out_tag_d   = TAG_PC;
          out_idx_d   = '0;
          out_data_d  = head_c.pc;
        end else if (push_req_c) begin
          // empty FIFO: present the PC straight from the commit port
          state_d     = S_ENTRY;
          beat_d      = 2'd0;
          out_valid_d = 1'b1;
          out_tag_d   = TAG_PC;
          out_idx_d   = '0;
          out_data_d  = commit_pc;
        end
      end
      S_ENTRY: begin
        if (hs_c) begin
          unique case (beat_q)
            2'd0: begin
              beat_d     = 2'd1;
              out_tag_d  = TAG_INST;
              out_data_d = head_c.inst;
            end
            2'd1: begin
              beat_d     = 2'd2;
              out_tag_d  = TAG_WB;
              out_data_d = wbinfo_c;
            end
            2'd2: begin
              if (head_c.we) begin
                beat_d     = 2'd3;
                out_tag_d  = TAG_WDATA;
                out_data_d = head_c.wdata;
              end else begin
                pop_c = 1'b1;
              end
            end
            default: pop_c = 1'b1;
          endcase
          if (pop_c) begin
            state_d     = S_IDLE;
            beat_d      = 2'd0;
            out_valid_d = 1'b0;
            out_tag_d   = '0;
            out_idx_d   = '0;
            out_data_d  = '0;
            rd_ptr_d    = rd_ptr_q + PW'(1);
            if (head_c.we && (head_c.waddr != '0)) shadow_d[head_c.waddr] = head_c.wdata;
          end
        end
      end
      S_SNAP: begin
        if (hs_c) begin
          if (sidx_q == AW'(NREG - 1)) begin
            state_d     = S_IDLE;
            sidx_d      = '0;
            out_valid_d = 1'b0;
            out_tag_d   = '0;
            out_idx_d   = '0;
            out_data_d  = '0;
            snap_busy_d = 1'b0;
          end else begin
            sidx_d      = sidx_q + AW'(1);
            out_idx_d   = sidx_d;
            out_data_d  = shadow_q[sidx_d];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // a full FIFO still accepts a record when its head retires this cycle
    push_c = push_req_c & ((count_q != CW'(DEPTH)) | pop_c);
    drop_c = push_req_c & ~push_c;
    if (push_c) wr_ptr_d = wr_ptr_q + PW'(1);
    count_d = count_q + CW'(push_c) - CW'(pop_c);
    if (drop_c) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end
  end

  // Control, status, output and shadow register state
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      beat_q      <= 2'd0;
      sidx_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_idx_q   <= '0;
      snap_busy_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < NREG; i++) shadow_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      sidx_q      <= sidx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      out_idx_q   <= out_idx_d;
      snap_busy_q <= snap_busy_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      shadow_q    <= shadow_d;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers
  always_ff @(posedge clk_in) begin
    if (push_c) mem_q[wr_ptr_q] <= in_c;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign out_idx   = out_idx_q;
  assign snap_busy = snap_busy_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
